// File: rtl/rr_arb8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb8_ctrl
// Purpose  : Eight-way round-robin arbiter with registered one-hot grant,
//            binary owner index, hold-limit preemption and a one-cycle
//            turnaround gap after every grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb8_ctrl #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       revoked
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] c_HOLD_LAST = HW'(MAX_HOLD - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]    state_q,   state_d;
   logic [2:0]    owner_q,   owner_d;
   logic [2:0]    ptr_q,     ptr_d;
   logic [HW-1:0] hold_q,    hold_d;
   logic [7:0]    gnt_q,     gnt_d;
   logic [2:0]    idx_q,     idx_d;
   logic          valid_q,   valid_d;
   logic          revoked_q, revoked_d;

   logic [2:0]    w_pick;
   logic [7:0]    w_others;

   // Round-robin scan: first set request starting at ptr, wrapping mod 8
   always_comb begin
      logic       found;
      logic [2:0] cand;
      found  = 1'b0;
      w_pick = 3'd0;
      cand   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!found && req[cand]) begin
            found  = 1'b1;
            w_pick = cand;
         end
      end
   end

   // Requests from anyone other than the current owner
   always_comb begin
      w_others = req & ~(8'd1 << owner_q);
   end

   // State register: FSM, arbitration state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         owner_q   <= 3'd0;
         ptr_q     <= 3'd0;
         hold_q    <= '0;
         gnt_q     <= 8'd0;
         idx_q     <= 3'd0;
         valid_q   <= 1'b0;
         revoked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         revoked_q <= revoked_d;
      end
   end

   // Next-state logic: grant from IDLE; release beats preemption in BUSY
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      revoked_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req != 8'd0) begin
               owner_d = w_pick;
               hold_d  = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!req[owner_q]) begin
               state_d = S_IDLE;
               ptr_d   = owner_q + 3'd1;
            end else if ((hold_q == c_HOLD_LAST) && (w_others != 8'd0)) begin
               state_d   = S_IDLE;
               ptr_d     = owner_q + 3'd1;
               revoked_d = 1'b1;
            end else if (hold_q != c_HOLD_LAST) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from next state, so outputs register alongside the state
   always_comb begin
      gnt_d   = 8'd0;
      idx_d   = 3'd0;
      valid_d = 1'b0;
      if (state_d == S_BUSY) begin
         gnt_d   = 8'd1 << owner_d;
         idx_d   = owner_d;
         valid_d = 1'b1;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
   assign revoked   = revoked_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb8_ctrl
// Purpose  : Directed scoreboard bench for rr_arb8_ctrl (MAX_HOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb8_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       revoked;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic       rv;
      string      tag;
   } exp_t;

   exp_t sb_q[$];

   rr_arb8_ctrl #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .revoked   (revoked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one edge, queue the expected outputs, then compare after the edge
   task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] eg,
                       input logic [2:0] ei, input logic ev, input logic erv,
                       input string tag);
      exp_t e;
      exp_t x;
      rst = r;
      req = rq;
      e.gnt = eg; e.idx = ei; e.valid = ev; e.rv = erv; e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL %s scoreboard empty", tag);
         return;
      end
      x = sb_q.pop_front();
      tests_run++;
      assert (gnt === x.gnt) else begin
         tests_failed++;
         $error("FAIL %s gnt: got %b want %b", x.tag, gnt, x.gnt);
      end
      tests_run++;
      assert (gnt_idx === x.idx) else begin
         tests_failed++;
         $error("FAIL %s gnt_idx: got %0d want %0d", x.tag, gnt_idx, x.idx);
      end
      tests_run++;
      assert (gnt_valid === x.valid) else begin
         tests_failed++;
         $error("FAIL %s gnt_valid: got %b want %b", x.tag, gnt_valid, x.valid);
      end
      tests_run++;
      assert (revoked === x.rv) else begin
         tests_failed++;
         $error("FAIL %s revoked: got %b want %b", x.tag, revoked, x.rv);
      end
   endtask

   task automatic own(input logic r, input logic [7:0] rq, input int o, input string tag);
      logic [7:0] g;
      g = 8'd1 << o;
      step(r, rq, g, 3'(o), 1'b1, 1'b0, tag);
   endtask

   task automatic gap(input logic r, input logic [7:0] rq, input logic rv, input string tag);
      step(r, rq, 8'd0, 3'd0, 1'b0, rv, tag);
   endtask

   initial begin
      rst = 1'b1;
      req = 8'd0;

      // Reset and first grant
      gap(1'b1, 8'b0000_0100, 1'b0, "reset0");
      gap(1'b1, 8'b0000_0100, 1'b0, "reset1");
      own(1'b0, 8'b0000_0100, 2, "first_grant");
      gap(1'b0, 8'h00, 1'b0, "first_release");

      // Rotation by preemption, starting from a fresh ptr=0
      gap(1'b1, 8'hFF, 1'b0, "rot_reset");
      for (int o = 0; o < 9; o++) begin
         for (int c = 0; c < 4; c++) own(1'b0, 8'hFF, o % 8, $sformatf("rot_own%0d_c%0d", o, c));
         gap(1'b0, 8'hFF, 1'b1, $sformatf("rot_gap%0d", o));
      end

      // Release and wrap (ptr=1 here)
      own(1'b0, 8'b1100_0001, 6, "wrap_own6");
      gap(1'b0, 8'b1000_0001, 1'b0, "wrap_rel6");
      own(1'b0, 8'b1000_0001, 7, "wrap_own7");
      own(1'b0, 8'b1000_0001, 7, "wrap_hold7");
      gap(1'b0, 8'b0000_0001, 1'b0, "wrap_rel7");
      own(1'b0, 8'b0000_0001, 0, "wrap_own0");
      gap(1'b0, 8'h00, 1'b0, "wrap_rel0");

      // Sole holder is never preempted
      for (int c = 0; c < 40; c++) own(1'b0, 8'b0010_0000, 5, $sformatf("sole_c%0d", c));
      gap(1'b0, 8'h00, 1'b0, "sole_rel");

      // Simultaneous release and new request (ptr=6 here)
      own(1'b0, 8'b0000_0100, 2, "sim_own2");
      own(1'b0, 8'b0000_0100, 2, "sim_hold2");
      gap(1'b0, 8'b0000_0010, 1'b0, "sim_rel2");
      own(1'b0, 8'b0000_0010, 1, "sim_own1");
      // Release coinciding with hold limit reached and others waiting
      for (int c = 0; c < 3; c++) own(1'b0, 8'b0000_0011, 1, $sformatf("relpre_c%0d", c));
      gap(1'b0, 8'b0000_0001, 1'b0, "relpre_rel");
      own(1'b0, 8'b0000_0001, 0, "relpre_own0");
      gap(1'b0, 8'h00, 1'b0, "relpre_rel0");

      // Reset while owner 5 holds with hold_cnt=2 (ptr=1 here)
      own(1'b0, 8'b0010_0000, 5, "mid_own5");
      own(1'b0, 8'hFF, 5, "mid_hold1");
      own(1'b0, 8'hFF, 5, "mid_hold2");
      gap(1'b1, 8'hFF, 1'b0, "mid_reset");
      own(1'b0, 8'hFF, 0, "mid_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/rr_arb8_ctrl.md
# rr_arb8_ctrl

Round-robin arbiter that shares one resource among eight requesters and reports the current owner as a binary index, matching the 8-to-3 encoding convention used in the encoder blocks (bit i → index i). It sits between eight request lines and the shared resource. It issues one registered grant at a time, holds the grant until the owner releases, and preempts an owner that exceeds a hold limit while other requesters are waiting.

## Interface
- MAX_HOLD, 16, maximum consecutive BUSY cycles before preemption when others wait; legal range 2–256
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high; all state and outputs clear on the clock edge where rst=1
- req  input  8  request vector, bit i = requester i; a requester holds req high for as long as it needs the resource
- gnt  output 8  one-hot grant, registered; all zeros when no owner
- gnt_idx  output 3  binary index of the owner (one-hot-to-binary of gnt); 3'b000 when gnt_valid=0
- gnt_valid  output 1  1 while an owner holds the grant
- revoked  output 1  one-cycle pulse in the cycle after a preemption

## Operation
- Registered state: fsm state (IDLE, BUSY), owner[2:0], ptr[2:0] (round-robin start), hold_cnt (width clog2(MAX_HOLD)).
- Reset values: state=IDLE, ptr=0, owner=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_valid=0, revoked=0.
- IDLE: gnt=0, gnt_valid=0. If req≠0 at an edge, select the first set bit scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8). Set owner to that bit, load hold_cnt=0, and go to BUSY. If req=0, stay in IDLE.
- BUSY: gnt=one-hot(owner), gnt_idx=owner, gnt_valid=1. At each edge, evaluate in this priority order:
  - Release: req[owner]=0. Go to IDLE, set ptr=owner+1 mod 8, revoked stays 0.
  - Preempt: req[owner]=1, hold_cnt=MAX_HOLD-1, and (req with bit owner masked)≠0. Go to IDLE, set ptr=owner+1 mod 8, set revoked=1 for one cycle.
  - Otherwise: stay in BUSY. hold_cnt increments and saturates at MAX_HOLD-1, so a sole requester is never preempted.
- Any exit from BUSY spends exactly one cycle in IDLE with gnt=0 (turnaround gap) before the next grant.
- ptr changes only on exit from BUSY. The wrap from 7 goes to 0.
- Requests that pulse between edges are not seen. Only values sampled at the edge count.
- gnt_idx must always equal the binary encoding of gnt. When gnt_valid=1, gnt has exactly one bit set.

## Timing
- Grant latency: req sampled high at edge k in IDLE → gnt and gnt_valid high after edge k (1 cycle).
- Release latency: req[owner] sampled low at edge k → gnt=0 after edge k. The earliest next grant comes after edge k+1.
- Preemption: the owner receives exactly MAX_HOLD cycles of gnt_valid=1, then one gap cycle. revoked=1 during the gap cycle only.
- Release and a new request at the same edge: release wins, then the gap cycle. The new request is granted at the following edge under the updated ptr.
- Release and the preempt condition at the same edge: treated as a release, so revoked=0.
- rst=1 mid-grant: after that edge all outputs are 0 and ptr=0, regardless of req. Arbitration resumes on the first edge with rst=0.
- All outputs are registered. There are no combinational paths from req to any output.

## Test plan
- Reset/first grant: rst=1 for 2 cycles, then req=8'b00000100. Required: outputs 0 during reset, then gnt=8'b00000100, gnt_idx=3'b010, gnt_valid=1 one cycle after the sampling edge.
- Round-robin rotation via preemption: MAX_HOLD=4, req=8'hFF held constant. Required: owners 0,1,2,…,7,0 in order, each with 4 cycles of gnt_valid=1 followed by 1 gap cycle with revoked=1 and gnt=0.
- Release and wrap: owner 6 is active with req=8'b11000001. Drop bit 6. Required: the gap cycle, then grant to 7 (gnt_idx=111). Drop bit 7: grant to 0 (ptr wrapped). No revoked pulses.
- Sole holder: MAX_HOLD=4, req=8'b00100000 held for 40 cycles. Required: gnt_idx=3'b101 and gnt_valid=1 continuously after the first grant, revoked never asserted.
- Simultaneous events: owner 2 drops req at the same edge that bit 1 rises (req=8'b00000010). Required: one gap cycle, then grant to 1 (the scan wraps from ptr=3). revoked=0.
- Reset mid-operation: owner 5 is active with hold_cnt=2, assert rst for one cycle with req=8'hFF. Required: all outputs 0 after that edge. The first grant after reset goes to requester 0 (ptr=0).
